// File: rtl/jk_mod_counter_pkg.sv
// Shared JK command encoding and the excitation mapping used by the modulo counter.
package jk_mod_counter_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_cmd_e;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_COUNT = 2'b10,
    MODE_CLEAR = 2'b11
  } cnt_mode_e;

  // Load forces the target level; counting toggles only the bits that change.
  function automatic jk_cmd_e jk_cmd(input logic cur, input logic nxt, input cnt_mode_e mode);
    jk_cmd_e cmd;
    cmd = JK_HOLD;
    case (mode)
      MODE_LOAD:  cmd = nxt ? JK_SET : JK_RST;
      MODE_COUNT: cmd = (cur != nxt) ? JK_TOG : JK_HOLD;
      MODE_CLEAR: cmd = JK_RST;
      default:    cmd = JK_HOLD;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/jk_mod_counter_ff.sv
// Single-bit JK flip-flop with synchronous active-high clear.
// Latency: one clk edge; no flow control.
// No backpressure.
module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo counter built from per-bit JK flip-flops with parallel load.
// Latency: q/wrap/err update one edge after the request; tc is combinational.
// No backpressure: every cycle's controls are acted on.
module jk_mod_counter
  import jk_mod_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             err
);

  // One extra bit so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   q_inc;
  logic [WIDTH:0]   q_dec;
  logic [WIDTH:0]   count_nxt;
  logic [WIDTH-1:0] tgt;
  logic             load_ok;
  cnt_mode_e        mode;
  logic [1:0]       cmd [WIDTH];

  assign q_ext   = {1'b0, q};
  assign q_inc   = q_ext + 1'b1;
  assign q_dec   = q_ext - 1'b1;
  assign load_ok = ({1'b0, din} < MOD_W);

  // q_inc hitting MODULUS marks the up-wrap; a borrow out of q_dec marks the down-wrap.
  always_comb begin
    count_nxt = '0;
    if (q_ext >= MOD_W) begin
      count_nxt = '0;
    end else if (up) begin
      count_nxt = (q_inc == MOD_W) ? '0 : q_inc;
    end else begin
      count_nxt = q_dec[WIDTH] ? MAX_W : q_dec;
    end
  end

  always_comb begin
    mode = MODE_HOLD;
    tgt  = q;
    if (rst) begin
      mode = MODE_CLEAR;
      tgt  = '0;
    end else if (load) begin
      mode = MODE_LOAD;
      tgt  = load_ok ? din : '0;
    end else if (en) begin
      mode = MODE_COUNT;
      tgt  = count_nxt[WIDTH-1:0];
    end
  end

  assign tc = en & ~load & (up ? (q_inc == MOD_W) : (q_ext == '0));

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign cmd[i] = jk_cmd(q[i], tgt[i], mode);
    jk_ff u_ff (
      .clk (clk),
      .rst (rst),
      .j   (cmd[i][1]),
      .k   (cmd[i][0]),
      .q   (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      wrap <= tc;
      err  <= load & ~load_ok;
    end
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed checks of the JK modulo counter (WIDTH=4, MODULUS=10).
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] din;
  logic [3:0] q;
  logic       tc;
  logic       wrap;
  logic       err;

  int checks = 0;
  int fails  = 0;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
    .load (load),
    .din  (din),
    .q    (q),
    .tc   (tc),
    .wrap (wrap),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] eq, input logic ew, input logic ee);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
    chk({tag, ".err"}, 32'(err), 32'(ee));
  endtask

  initial begin
    int exp_q;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; din = '0;

    tick; tick;
    chk_state("reset", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    #1 chk("reset.tc_idle", 32'(tc), 32'd0);

    // Count up through the wrap: 1..9, 0, 1, 2
    en = 1'b1; up = 1'b1;
    exp_q = 0;
    for (int i = 1; i <= 12; i++) begin
      #1 chk("up.tc", 32'(tc), (exp_q == 9) ? 32'd1 : 32'd0);
      tick;
      exp_q = (exp_q == 9) ? 0 : exp_q + 1;
      chk_state("up", 4'(exp_q), (i == 10), 1'b0);
    end

    // Down wrap from 1: 0, 9, 8
    load = 1'b1; din = 4'd1; en = 1'b0;
    tick; chk_state("dn.load", 4'd1, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1; up = 1'b0;
    #1 chk("dn.tc1", 32'(tc), 32'd0);
    tick; chk_state("dn.s1", 4'd0, 1'b0, 1'b0);
    #1 chk("dn.tc0", 32'(tc), 32'd1);
    tick; chk_state("dn.s2", 4'd9, 1'b1, 1'b0);
    #1 chk("dn.tc9", 32'(tc), 32'd0);
    tick; chk_state("dn.s3", 4'd8, 1'b0, 1'b0);

    // Load beats enable
    load = 1'b1; din = 4'd7; en = 1'b1; up = 1'b1;
    tick; chk_state("ldpri", 4'd7, 1'b0, 1'b0);
    din = 4'd9;
    tick; chk_state("ld9", 4'd9, 1'b0, 1'b0);
    din = 4'd3;
    #1 chk("ld.tc_masked", 32'(tc), 32'd0);
    tick; chk_state("ld_at_max", 4'd3, 1'b0, 1'b0);

    // Illegal loads, including din == MODULUS
    en = 1'b0; din = 4'd12;
    tick; chk_state("ill12", 4'd0, 1'b0, 1'b1);
    load = 1'b0;
    tick; chk_state("ill12.after", 4'd0, 1'b0, 1'b0);
    load = 1'b1; din = 4'd10;
    tick; chk_state("ill10", 4'd0, 1'b0, 1'b1);
    load = 1'b0;
    tick; chk_state("ill10.after", 4'd0, 1'b0, 1'b0);

    // Reset mid-count
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 5; i++) tick;
    chk_state("mid.pre", 4'd5, 1'b0, 1'b0);
    rst = 1'b1;
    tick; chk_state("mid.rst", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick; chk_state("mid.resume", 4'd1, 1'b0, 1'b0);

    // Reset overrides an illegal load
    rst = 1'b1; load = 1'b1; din = 4'd12;
    tick; chk_state("rst_over_ld", 4'd0, 1'b0, 1'b0);
    rst = 1'b0; din = 4'd3;
    tick; chk_state("hold.load", 4'd3, 1'b0, 1'b0);

    // Hold for 4 cycles, then alternate direction
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("hold.tc", 32'(tc), 32'd0);
      tick; chk_state("hold", 4'd3, 1'b0, 1'b0);
    end
    en = 1'b1; up = 1'b1;
    tick; chk_state("dir1", 4'd4, 1'b0, 1'b0);
    up = 1'b0;
    tick; chk_state("dir2", 4'd3, 1'b0, 1'b0);
    up = 1'b1;
    tick; chk_state("dir3", 4'd4, 1'b0, 1'b0);
    up = 1'b0;
    tick; chk_state("dir4", 4'd3, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
JK_MOD_COUNTER -- requirements
Module: jk_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter bit width.
REQ-002 SHALL have parameter MODULUS, default 10, giving the count range 0..MODULUS-1, with 2 <= MODULUS <= 2**WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: count enable.
REQ-006 SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-007 SHALL have port load, input, 1 bit: parallel load request.
REQ-008 SHALL have port din, input, WIDTH bits: parallel load value.
REQ-009 SHALL have port q, output, WIDTH bits: current count, taken directly from the JK flip-flop outputs.
REQ-010 SHALL have port tc, output, 1 bit: combinational terminal count.
REQ-011 SHALL have port wrap, output, 1 bit: registered one-cycle pulse after a wrap.
REQ-012 SHALL have port err, output, 1 bit: registered one-cycle pulse after an out-of-range load.

Function
REQ-013 SHALL hold every count bit in its own JK flip-flop, with each bit's J/K driven by excitation logic derived from q and the controls.
REQ-014 SHALL apply a per-cycle priority of rst > load > en > hold.
REQ-015 SHALL, on load with din < MODULUS, set q = din on the next edge; per bit, a target of 1 drives J=1, K=0 and a target of 0 drives J=0, K=1.
REQ-016 SHALL, on load with din >= MODULUS, set q = 0 on the next edge and pulse err high for exactly one cycle.
REQ-017 SHALL, with en=1, up=1 and no load, set q to q+1, or to 0 when q == MODULUS-1.
REQ-018 SHALL, with en=1, up=0 and no load, set q to q-1, or to MODULUS-1 when q == 0.
REQ-019 SHALL, in counting mode, drive J=K=1 (toggle) on bits that change and J=K=0 (hold) on bits that do not.
REQ-020 SHALL hold q unchanged when en=0 and load=0, with J=K=0 on all bits.
REQ-021 SHALL drive tc = en & ~load & (up ? q == MODULUS-1 : q == 0), with zero latency.
REQ-022 SHALL register wrap high for one cycle on the edge where a wrap occurs, i.e. the cycle after tc was high.
REQ-023 SHALL ignore en during a load, so simultaneous load and en loads the value and produces no wrap pulse.
REQ-024 SHALL allow a direction change on any cycle, taking effect on the next edge with no dead cycle.
REQ-025 SHALL, if q is somehow >= MODULUS, go to 0 on the next counting edge in either direction.

Reset
REQ-026 SHALL, on rst high at a clock edge, set q = 0, wrap = 0 and err = 0, overriding load and en.
REQ-027 SHALL reset each bit through a J=0, K=1 command plus the flip-flop's own synchronous reset, so that reset asserted mid-count clears q on the next edge.
REQ-028 SHALL hold tc at 0 while q = 0 and en = 0 after reset.

Structure
REQ-029 SHALL place in a shared package:
- the JK command encoding: HOLD=00, RST=01, SET=10, TOG=11;
- the function mapping (current bit, next bit, mode) to a JK command.
REQ-030 SHALL instantiate one sub-module, jk_ff, WIDTH times; jk_ff is a 1-bit JK flip-flop with ports clk, rst, j, k, q and a synchronous active-high reset.
REQ-031 SHALL compute the next-count arithmetic at WIDTH+1 bits to avoid overflow before the modulus compare.

Verification
REQ-032 Reset then count: rst for 2 cycles, then en=1, up=1 for 12 cycles -> q goes 0..9, 0, 1; tc high while q=9; wrap high the cycle q returns to 0.
REQ-033 Down wrap: load din=1, then en=1, up=0 for 3 cycles -> q goes 1, 0, 9, 8; tc high at q=0; wrap pulses once.
REQ-034 Load priority: load=1, din=7 with en=1, up=1 -> q=7 next cycle, no wrap, err=0.
REQ-035 Illegal load: load=1, din=12 -> q=0 next cycle, err high for exactly one cycle.
REQ-036 Reset mid-count: at q=5 with en=1, assert rst for one cycle -> q=0 next edge, wrap=0, err=0, then counting resumes at 1.
REQ-037 Hold and direction: en=0 for 4 cycles at q=3 -> q stays 3 and tc=0; then en=1 with up toggled every cycle -> q goes 4, 3, 4, 3.
